// File: rtl/encoder_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
// Shared constants for the 8-to-3 request encoder: request count, index width,
// FSM state encoding, selection policy codes and a one-hot helper.
// No ports (package).
// ----------------------------------------------------------------------------
package encoder_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned IDX_W = 3;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PRESENT = 1'b1;

    // Selection policy codes for PRIO_MODE
    localparam int PRIO_FIXED = 0;
    localparam int PRIO_RR    = 1;

    // Index to one-hot request mask
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] one;
        one = '0;
        one[idx] = 1'b1;
        return one;
    endfunction

endpackage

// File: rtl/encoder_8to3_req_prio_pick8.sv
// ----------------------------------------------------------------------------
// prio_pick8
// Combinational circular priority picker over 8 request bits. Scans
// start_i, start_i+1, ... (mod 8) and returns the first set index.
// Ports:
//   req_i   [7:0] request vector
//   start_i [2:0] index with highest priority for this scan
//   idx_o   [2:0] selected index (0 when nothing is found)
//   found_o       at least one request bit is set
// ----------------------------------------------------------------------------
module prio_pick8
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;

    always_comb begin
        // Rotate so that bit start_i lands at position 0; offset k then maps
        // back to index start_i + k with natural 3-bit wrap.
        dbl     = {req_i, req_i} >> start_i;
        rot     = dbl[N_REQ-1:0];
        off     = '0;
        found_o = 1'b0;
        // Downward scan so the lowest offset is the one left standing.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off     = IDX_W'(k);
                found_o = 1'b1;
            end
        end
        idx_o = found_o ? start_i + off : '0;
    end

endmodule

// File: rtl/encoder_8to3_req.sv
// ----------------------------------------------------------------------------
// encoder_8to3_req
// Collects eight request lines into a pending register and presents them one
// at a time as a 3-bit index with a valid/ack handshake. Fixed priority
// (Y0 highest) or round-robin after the last granted index.
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   E                capture enable for Y0..Y7
//   Y0..Y7           request lines (level sampled every edge while E=1)
//   ack              consumer accepts the presented index (only while valid)
//   adr0..adr2       presented index, adr0 = LSB; held while valid=0
//   valid            adr holds a pending request index
//   any              OR of the pending register
//   ovf              one-cycle pulse: a request coalesced into a pending bit
// ----------------------------------------------------------------------------
module encoder_8to3_req
    import encoder_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_FIXED
) (
    input  logic clk,
    input  logic rst,
    input  logic E,
    input  logic Y0,
    input  logic Y1,
    input  logic Y2,
    input  logic Y3,
    input  logic Y4,
    input  logic Y5,
    input  logic Y6,
    input  logic Y7,
    input  logic ack,
    output logic adr0,
    output logic adr1,
    output logic adr2,
    output logic valid,
    output logic any,
    output logic ovf
);

    logic [N_REQ-1:0] p_q, p_d;
    logic [0:0]       state_q, state_d;
    logic [IDX_W-1:0] adr_q, adr_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic             ovf_q, ovf_d;

    logic [N_REQ-1:0] req_vec;
    logic [N_REQ-1:0] set_vec;
    logic [N_REQ-1:0] clr_vec;
    logic [N_REQ-1:0] p_sel;
    logic [IDX_W-1:0] start_idx;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             presenting;

    assign req_vec    = {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0};
    assign presenting = (state_q == ST_PRESENT);

    // Capture and clear; set wins over clear for the same bit.
    always_comb begin
        set_vec = E ? req_vec : '0;
        clr_vec = (presenting && ack) ? idx_to_onehot(adr_q) : '0;
        p_sel   = p_q & ~clr_vec;
        p_d     = p_sel | set_vec;
        ovf_d   = |(set_vec & p_sel);
    end

    // Round-robin resumes just after the last grant; last resets to 7 so the
    // first scan starts at 0.
    assign start_idx = (PRIO_MODE == PRIO_RR) ? last_q + 3'd1 : '0;

    prio_pick8 u_pick (
        .req_i   (p_sel),
        .start_i (start_idx),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_PRESENT;
                    adr_d   = pick_idx;
                    last_d  = pick_idx;
                end
            end
            ST_PRESENT: begin
                if (ack) begin
                    if (pick_found) begin
                        adr_d  = pick_idx;
                        last_d = pick_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q     <= '0;
            state_q <= ST_IDLE;
            adr_q   <= '0;
            last_q  <= 3'd7;
            ovf_q   <= 1'b0;
        end else begin
            p_q     <= p_d;
            state_q <= state_d;
            adr_q   <= adr_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
        end
    end

    assign adr0  = adr_q[0];
    assign adr1  = adr_q[1];
    assign adr2  = adr_q[2];
    assign valid = presenting;
    assign any   = |p_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_encoder_8to3_req.sv
// Bench for encoder_8to3_req: a fixed-priority and a round-robin instance share
// one stimulus; a behavioural model of each is checked every cycle, and
// directed literal expectations pin the model at key points.
module tb_encoder_8to3_req;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, E, ack;
    logic [7:0] y;

    logic [2:0] d_adr [2];
    logic       d_v   [2];
    logic       d_any [2];
    logic       d_ovf [2];

    logic a0f, a1f, a2f, a0r, a1r, a2r;
    assign d_adr[0] = {a2f, a1f, a0f};
    assign d_adr[1] = {a2r, a1r, a0r};

    encoder_8to3_req #(.PRIO_MODE(0)) u_fix (
        .clk(clk), .rst(rst), .E(E),
        .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
        .Y4(y[4]), .Y5(y[5]), .Y6(y[6]), .Y7(y[7]),
        .ack(ack), .adr0(a0f), .adr1(a1f), .adr2(a2f),
        .valid(d_v[0]), .any(d_any[0]), .ovf(d_ovf[0])
    );

    encoder_8to3_req #(.PRIO_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .E(E),
        .Y0(y[0]), .Y1(y[1]), .Y2(y[2]), .Y3(y[3]),
        .Y4(y[4]), .Y5(y[5]), .Y6(y[6]), .Y7(y[7]),
        .ack(ack), .adr0(a0r), .adr1(a1r), .adr2(a2r),
        .valid(d_v[1]), .any(d_any[1]), .ovf(d_ovf[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_pend [2][8];
    logic       m_v    [2];
    int         m_adr  [2];
    int         m_last [2];
    logic       m_ovf  [2];
    bit         m_ok = 0;

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) m_pend[m][i] = 0;
                m_v[m] = 0; m_adr[m] = 0; m_last[m] = 7; m_ovf[m] = 0;
            end else begin
                bit elig [8];
                int start, pick, acked;
                acked = (m_v[m] && ack) ? m_adr[m] : -1;
                for (int i = 0; i < 8; i++) elig[i] = m_pend[m][i] && (i != acked);
                m_ovf[m] = 0;
                for (int i = 0; i < 8; i++) if (E && y[i] && elig[i]) m_ovf[m] = 1;
                start = (m == 1) ? (m_last[m] + 1) % 8 : 0;
                pick  = -1;
                for (int k = 0; k < 8; k++)
                    if (pick < 0 && elig[(start + k) % 8]) pick = (start + k) % 8;
                if (!m_v[m] || ack) begin
                    if (pick >= 0) begin
                        m_v[m] = 1; m_adr[m] = pick; m_last[m] = pick;
                    end else begin
                        m_v[m] = 0;
                    end
                end
                for (int i = 0; i < 8; i++) m_pend[m][i] = elig[i] || (E && y[i]);
            end
        end
        if (rst) m_ok = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_ok) begin
            for (int m = 0; m < 2; m++) begin
                bit a;
                a = 0;
                for (int i = 0; i < 8; i++) a = a | m_pend[m][i];
                check($sformatf("model_valid[%0d]", m), 8'(d_v[m]), 8'(m_v[m]));
                check($sformatf("model_adr[%0d]", m), 8'(d_adr[m]), 8'(m_adr[m]));
                check($sformatf("model_any[%0d]", m), 8'(d_any[m]), 8'(a));
                check($sformatf("model_ovf[%0d]", m), 8'(d_ovf[m]), 8'(m_ovf[m]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input int m, input logic v, input logic [2:0] a,
                       input logic an);
        check({name, "_valid"}, 8'(d_v[m]), 8'(v));
        check({name, "_adr"}, 8'(d_adr[m]), 8'(a));
        check({name, "_any"}, 8'(d_any[m]), 8'(an));
    endtask

    logic [2:0] exp_f [4];
    logic [2:0] exp_r [4];

    initial begin
        exp_f = '{3'd0, 3'd2, 3'd5, 3'd7};
        exp_r = '{3'd5, 3'd7, 3'd0, 3'd2};
        rst = 1; E = 0; y = 8'h00; ack = 0;
        tick(); tick();
        lit("reset_f", 0, 0, 3'd0, 0);
        lit("reset_r", 1, 0, 3'd0, 0);
        check("reset_ovf", 8'(d_ovf[0] | d_ovf[1]), 8'd0);

        // Single Y3 pulse, ack tied high
        rst = 0; E = 1; y = 8'h08; ack = 1;
        tick();
        y = 8'h00;
        check("y3_captured_any", 8'(d_any[0]), 8'd1);
        check("y3_not_yet_valid", 8'(d_v[0]), 8'd0);
        tick();
        lit("y3_grant_f", 0, 1, 3'd3, 1);
        lit("y3_grant_r", 1, 1, 3'd3, 1);
        tick();
        lit("y3_done_f", 0, 0, 3'd3, 0);

        // Y0,Y2,Y5,Y7 burst, ack held
        y = 8'hA5;
        tick();
        y = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("burst_f%0d", i), 8'(d_adr[0]), 8'(exp_f[i]));
            check($sformatf("burst_r%0d", i), 8'(d_adr[1]), 8'(exp_r[i]));
        end
        tick();
        check("burst_end_valid", 8'(d_v[0] | d_v[1]), 8'd0);

        // Round robin wrap: present 2, then add 7 and 0
        ack = 0; y = 8'h04;
        tick();
        y = 8'h00;
        tick();
        lit("rr_pre2", 1, 1, 3'd2, 1);
        y = 8'h81;
        tick();
        y = 8'h00; ack = 1;
        tick();
        check("rr_next7", 8'(d_adr[1]), 8'd7);
        check("fix_next0", 8'(d_adr[0]), 8'd0);
        tick();
        check("rr_wrap0", 8'(d_adr[1]), 8'd0);
        check("fix_then7", 8'(d_adr[0]), 8'd7);
        tick();
        check("rr_drained", 8'(d_v[1]), 8'd0);

        // Re-request of the presented bit on its ack edge
        ack = 0; y = 8'h04;
        tick();
        y = 8'h00;
        tick();
        lit("rereq_pre", 1, 1, 3'd2, 1);
        ack = 1; y = 8'h04;
        tick();
        y = 8'h00;
        lit("rereq_kept", 1, 0, 3'd2, 1);
        check("rereq_no_ovf", 8'(d_ovf[1]), 8'd0);
        tick();
        lit("rereq_regrant", 1, 1, 3'd2, 1);
        tick();
        lit("rereq_done", 1, 0, 3'd2, 0);

        // Overflow: Y4 held two cycles, ack low
        ack = 0; y = 8'h10;
        tick();
        tick();
        y = 8'h00;
        check("ovf_pulse", 8'(d_ovf[0]), 8'd1);
        lit("ovf_grant4", 0, 1, 3'd4, 1);
        tick();
        check("ovf_once", 8'(d_ovf[0]), 8'd0);
        ack = 1;
        tick();
        lit("ovf_single_grant", 0, 0, 3'd4, 0);
        ack = 0;

        // Capture disabled
        E = 0; y = 8'h02;
        tick();
        y = 8'h00;
        tick();
        check("e0_no_any", 8'(d_any[0] | d_any[1]), 8'd0);
        check("e0_no_valid", 8'(d_v[0] | d_v[1]), 8'd0);

        // Reset mid-PRESENT, with Y and ack active on the reset edge
        E = 1; y = 8'hF0;
        tick();
        y = 8'h00;
        tick();
        lit("pre_rst_f", 0, 1, 3'd4, 1);
        lit("pre_rst_r", 1, 1, 3'd5, 1);
        rst = 1; y = 8'hFF; ack = 1;
        tick();
        rst = 0; ack = 0; y = 8'h40;
        lit("mid_rst_f", 0, 0, 3'd0, 0);
        lit("mid_rst_r", 1, 0, 3'd0, 0);
        check("mid_rst_ovf", 8'(d_ovf[1]), 8'd0);
        tick();
        y = 8'h00;
        tick();
        lit("post_rst_r6", 1, 1, 3'd6, 1);
        ack = 1;
        tick();
        tick();
        lit("final_r", 1, 0, 3'd6, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_8to3_req.md
Name: encoder_8to3_req

Overview:
- Request-side counterpart of the 3-to-8 address decoder: collects eight one-bit request lines Y0..Y7 and returns them, one at a time, as a 3-bit binary code on adr0..adr2.
- Requests are latched into a pending register and presented one at a time with a valid/ack handshake.
- Selection is fixed-priority or round-robin.
- Sits between decoder-driven request sources and the unit that services the encoded address.

Parameters:
- PRIO_MODE, 0, selection policy: 0 = fixed priority (Y0 highest); 1 = round-robin, starting after the last granted index.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- E  input  1  capture enable; when 0, Y0..Y7 are ignored
- Y0..Y7  input  1 each  request lines; a level is sampled on every edge while E=1
- ack  input  1  consumer accepts the presented code; meaningful only while valid=1
- adr0, adr1, adr2  output  1 each  encoded index, adr0 = LSB
- valid  output  1  adr0..adr2 hold a pending request index
- any  output  1  OR of the pending register (registered view)
- ovf  output  1  one-cycle pulse: a request hit an already-pending bit and was coalesced

Behaviour:
- State
  - P[7:0]: pending register.
  - FSM: IDLE, PRESENT.
  - last[2:0]: last granted index.
- Reset (rst=1 at an edge, any state, mid-handshake included)
  - P=0, state=IDLE, valid=0, adr=000, ovf=0, last=7.
  - rst overrides E, Y and ack on the same edge.
- Capture, each edge:
  - set = E ? Y : 0; clr = one-hot(adr) if (valid & ack), else 0.
  - P_next = (P & ~clr) | set. Set wins over clear for the same bit.
- Overflow
  - ovf_next = |(set & P & ~clr).
  - Registered, so it pulses the cycle after the offending edge.
  - Nothing is lost except the duplicate.
- Selection (combinational, from registered P only)
  - Uses P_sel = P & ~clr. A request captured on edge N is first eligible for selection in the cycle after edge N.
  - PRIO_MODE=0: lowest set index of P_sel.
  - PRIO_MODE=1: first set index of P_sel scanning last+1, last+2, ... with modulo-8 wrap (7 wraps to 0).
- FSM transitions
  - IDLE: if P_sel != 0, load adr = selected index, valid=1, last=index, go to PRESENT; else stay, valid=0.
  - PRESENT: adr and valid are held stable until ack=1.
  - On ack: if P_sel != 0, load the next selected index and stay in PRESENT (back-to-back, no bubble); else valid=0 and go to IDLE.
  - ack while valid=0 is ignored.
- Latency
  - Y sampled at edge N gives valid=1 after edge N+1 when IDLE.
  - Throughput is one grant per cycle while ack is held high.
- Outputs
  - adr holds its last value when valid=0.
  - any = |P; it includes the currently presented bit until that bit is acknowledged.
- Re-request: if the presented bit k is re-asserted on its ack edge, it stays pending and is presented again later (immediately, if no other bit is pending).
- E=0: the capture path is gated only; the pending queue drains normally through the handshake.

Decomposition:
- Shared package encoder_pkg:
  - IDLE/PRESENT state encoding
  - N_REQ=8, IDX_W=3
  - PRIO_FIXED=0, PRIO_RR=1 constants
- One sub-module, prio_pick8: combinational 8-bit request vector plus 3-bit start index to 3-bit index and found flag.
  - Fixed mode drives start=0.
  - The top holds P, the FSM, last and ovf.

Test Plan:
- Reset, then E=1 with Y3 pulsed one cycle and ack tied 1 -> valid=1 with adr=011 one cycle later, for exactly one cycle; afterwards any=0, valid=0.
- PRIO_MODE=0, E=1, Y0..Y7=10100101 (Y0,Y2,Y5,Y7) for one cycle, ack held 1 -> adr sequence 000, 010, 101, 111 on consecutive cycles; valid falls after 111.
- PRIO_MODE=1, last=2 (after granting index 2), P=10000101 -> next grant 7, then 0 (wrap); with P=00000100 only, index 2 is re-granted.
- Y4 held for 2 cycles with ack=0 and no pending bits -> ovf pulses once; after ack a single grant of 100 occurs and any drops to 0. With E=0, pulsing Y1 -> no capture, no valid.
- Assert rst mid-PRESENT with P=11110000 -> next cycle valid=0, any=0, adr=000. Then Y6 with PRIO_MODE=1 -> grant 110 (search restarts at 0, since last=7).
